blocklock_fromgearbox: RTL and testbench

//  RX-side counterpart of the TX gearbox feeder. Consumes 64b data + 2b sync header from the

---
 rtl/blocklock_fromgearbox_pkg.sv | 25 ++
 rtl/blocklock_fromgearbox.sv | 146 ++++++++++++++
 tb/tb_blocklock_fromgearbox.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/blocklock_fromgearbox_pkg.sv
// Shared 64B/66B PCS definitions: sync header codes, idle block and block-lock FSM states.
// Imported by the RX block-lock logic and the TX gearbox feeder.
package blocklock_fromgearbox_pkg;

    localparam logic [1:0]  SYNC_DATA  = 2'b01;
    localparam logic [1:0]  SYNC_CTRL  = 2'b10;
    // Control block of type 0x1E with all-idle payload, laid out as {header, data}.
    localparam logic [65:0] IDLE_BLOCK = {SYNC_CTRL, 64'h0000_0000_0000_001E};

    localparam int DEF_SH_CNT_MAX   = 64;
    localparam int DEF_SH_INVLD_MAX = 16;
    localparam int DEF_SLIP_WAIT    = 32;

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        TEST_SH   = 2'd1,
        SLIP      = 2'd2,
        WAIT_SLIP = 2'd3
    } lock_state_e;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/blocklock_fromgearbox.sv
// RX 66b block-lock: tests gearbox sync headers, slips the gearbox until lock is found,
// and forwards {header, data} downstream with one cycle of latency while locked.
module blocklock_fromgearbox
    import blocklock_fromgearbox_pkg::*;
#(
    parameter int SH_CNT_MAX   = DEF_SH_CNT_MAX,
    parameter int SH_INVLD_MAX = DEF_SH_INVLD_MAX,
    parameter int SLIP_WAIT    = DEF_SLIP_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dat_i,
    input  logic [1:0]  head_i,
    input  logic        dat_vld_i,
    input  logic        head_vld_i,
    output logic        slip_o,
    output logic [65:0] dat_o,
    output logic        vld_o,
    output logic        block_lock,
    output logic        sh_err_o
);

    localparam int ShW   = $clog2(SH_CNT_MAX + 1);
    localparam int InvW  = $clog2(SH_INVLD_MAX + 1);
    localparam int WaitW = $clog2(SLIP_WAIT);

    lock_state_e      state_q, state_d;
    logic [ShW-1:0]   sh_cnt_q, sh_cnt_d, sh_inc;
    logic [InvW-1:0]  inv_cnt_q, inv_cnt_d, inv_inc;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             lock_q, lock_d;
    logic             sh_err_q, sh_err_d;
    logic [65:0]      dat_q;
    logic             vld_q;
    logic             hdr_ok;

    assign hdr_ok  = sh_is_valid(head_i);
    assign sh_inc  = sh_cnt_q + ShW'(1);
    assign inv_inc = inv_cnt_q + InvW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCK_INIT;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
            sh_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
            sh_err_q   <= sh_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        sh_err_d   = 1'b0;
        unique case (state_q)
            LOCK_INIT: begin
                lock_d    = 1'b0;
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                state_d   = TEST_SH;
            end
            // Pause cycles (head_vld_i low) leave every counter and the state untouched.
            TEST_SH: begin
                if (head_vld_i) begin
                    if (!lock_q) begin
                        if (!hdr_ok) begin
                            state_d = SLIP;
                        end else if (sh_inc == ShW'(SH_CNT_MAX)) begin
                            lock_d    = 1'b1;
                            sh_cnt_d  = '0;
                            inv_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_inc;
                        end
                    end else begin
                        sh_err_d = !hdr_ok;
                        // Losing lock takes priority over closing a clean window.
                        if (!hdr_ok && (inv_inc == InvW'(SH_INVLD_MAX))) begin
                            lock_d    = 1'b0;
                            state_d   = SLIP;
                            sh_cnt_d  = sh_inc;
                            inv_cnt_d = inv_inc;
                        end else if (sh_inc == ShW'(SH_CNT_MAX)) begin
                            sh_cnt_d  = '0;
                            inv_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_inc;
                            if (!hdr_ok) begin
                                inv_cnt_d = inv_inc;
                            end
                        end
                    end
                end
            end
            SLIP: begin
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                wait_cnt_d = '0;
                state_d    = WAIT_SLIP;
            end
            WAIT_SLIP: begin
                if (wait_cnt_q == WaitW'(SLIP_WAIT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = TEST_SH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: begin
                state_d = LOCK_INIT;
            end
        endcase
    end

    // Output register: vld_o uses the lock status from before this cycle's update,
    // so the locking block is dropped and the block that loses lock still goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            if (dat_vld_i) begin
                dat_q <= {head_i, dat_i};
            end
            vld_q <= dat_vld_i & head_vld_i & lock_q;
        end
    end

    assign slip_o     = (state_q == SLIP);
    assign dat_o      = dat_q;
    assign vld_o      = vld_q;
    assign block_lock = lock_q;
    assign sh_err_o   = sh_err_q;

endmodule

// File: tb/tb_blocklock_fromgearbox.sv
// Directed bench for blocklock_fromgearbox: lock acquisition, slip spacing, lock loss,
// pause cycles and asynchronous reset, checked with immediate assertions.
module tb_blocklock_fromgearbox;
    import blocklock_fromgearbox_pkg::*;

    logic        clk;
    logic        rst;
    logic [63:0] dat_i;
    logic [1:0]  head_i;
    logic        dat_vld_i;
    logic        head_vld_i;
    logic        slip_o;
    logic [65:0] dat_o;
    logic        vld_o;
    logic        block_lock;
    logic        sh_err_o;

    int          total;
    int          bad;
    int          blockNum;
    int          slipSeen;
    int          errSeen;
    logic [65:0] lastDat;

    blocklock_fromgearbox dut (
        .clk        (clk),
        .rst        (rst),
        .dat_i      (dat_i),
        .head_i     (head_i),
        .dat_vld_i  (dat_vld_i),
        .head_vld_i (head_vld_i),
        .slip_o     (slip_o),
        .dat_o      (dat_o),
        .vld_o      (vld_o),
        .block_lock (block_lock),
        .sh_err_o   (sh_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one gearbox beat, let it be sampled, then look at outputs 1 ns after the edge.
    task automatic applyStimulus(input logic [1:0] hd, input logic dv, input logic hv);
        head_i     = hd;
        dat_i      = {32'hD00D_F00D, 32'(blockNum)};
        dat_vld_i  = dv;
        head_vld_i = hv;
        if (dv) lastDat = {hd, 32'hD00D_F00D, 32'(blockNum)};
        blockNum++;
        @(posedge clk);
        #1;
        if (slip_o) slipSeen++;
        if (sh_err_o) errSeen++;
    endtask

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0; blockNum = 0; slipSeen = 0; errSeen = 0; lastDat = '0;
        rst = 1'b1; head_i = 2'b00; dat_i = '0; dat_vld_i = 1'b0; head_vld_i = 1'b0;

        $display("[TB] reset state");
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        lastDat = '0;
        checkOutput("rst_dat", dat_o, 66'(0));
        checkOutput("rst_vld", 66'(vld_o), 66'(0));
        checkOutput("rst_lock", 66'(block_lock), 66'(0));
        checkOutput("rst_slip", 66'(slip_o), 66'(0));
        checkOutput("rst_err", 66'(sh_err_o), 66'(0));
        rst = 1'b0;

        $display("[TB] T1 lock acquisition");
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        checkOutput("t1_init_lock", 66'(block_lock), 66'(0));
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(SYNC_DATA, 1'b1, 1'b1);
            if (i == 63) checkOutput("t1_lock_63", 66'(block_lock), 66'(0));
        end
        checkOutput("t1_lock_64", 66'(block_lock), 66'(1));
        checkOutput("t1_vld_64", 66'(vld_o), 66'(0));
        applyStimulus(SYNC_CTRL, 1'b1, 1'b1);
        checkOutput("t1_vld_65", 66'(vld_o), 66'(1));
        checkOutput("t1_dat_65", dat_o, lastDat);

        $display("[TB] T3 fifteen errors tolerated, sixteenth drops lock");
        errSeen = 0; slipSeen = 0;
        for (int p = 2; p <= 64; p++) begin
            if (p <= 16) applyStimulus((p % 2 == 0) ? 2'b00 : 2'b11, 1'b1, 1'b1);
            else applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        end
        checkOutput("t3_err_cnt15", 66'(errSeen), 66'(15));
        checkOutput("t3_lock_win", 66'(block_lock), 66'(1));
        checkOutput("t3_no_slip", 66'(slipSeen), 66'(0));
        errSeen = 0;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(2'b11, 1'b1, 1'b1);
            if (k == 15) checkOutput("t3_lock_15", 66'(block_lock), 66'(1));
        end
        checkOutput("t3_lock_16", 66'(block_lock), 66'(0));
        checkOutput("t3_slip", 66'(slip_o), 66'(1));
        checkOutput("t3_err_16", 66'(sh_err_o), 66'(1));
        checkOutput("t3_err_cnt16", 66'(errSeen), 66'(16));
        checkOutput("t3_loss_vld", 66'(vld_o), 66'(1));
        checkOutput("t3_loss_dat", dat_o, lastDat);
        slipSeen = 0;
        for (int w = 1; w <= 33; w++) applyStimulus(2'b11, 1'b1, 1'b1);
        checkOutput("t3_wait_noslip", 66'(slipSeen), 66'(0));
        checkOutput("t3_wait_vld", 66'(vld_o), 66'(0));

        $display("[TB] T2 slip while unlocked");
        for (int c = 1; c <= 10; c++) begin
            applyStimulus((c == 10) ? 2'b00 : SYNC_DATA, 1'b1, 1'b1);
            if (c == 9) checkOutput("t2_slip_9", 66'(slip_o), 66'(0));
        end
        checkOutput("t2_slip_10", 66'(slip_o), 66'(1));
        slipSeen = 0;
        for (int w = 1; w <= 33; w++) applyStimulus(2'b00, 1'b1, 1'b1);
        checkOutput("t2_wait_noslip", 66'(slipSeen), 66'(0));
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(SYNC_DATA, 1'b1, 1'b1);
            if (i == 63) checkOutput("t2_lock_63", 66'(block_lock), 66'(0));
        end
        checkOutput("t2_lock_64", 66'(block_lock), 66'(1));

        $display("[TB] T4 loss on last header of window");
        slipSeen = 0;
        for (int p = 1; p <= 64; p++) begin
            applyStimulus((p <= 48) ? SYNC_CTRL : 2'b00, 1'b1, 1'b1);
            if (p == 63) checkOutput("t4_lock_63", 66'(block_lock), 66'(1));
        end
        checkOutput("t4_lock_64", 66'(block_lock), 66'(0));
        checkOutput("t4_slip", 66'(slip_o), 66'(1));
        for (int w = 1; w <= 33; w++) applyStimulus(SYNC_DATA, 1'b1, 1'b1);

        $display("[TB] T5 pause cycles");
        slipSeen = 0;
        for (int c = 1; c <= 65; c++) begin
            if (c % 33 == 0) applyStimulus(2'b00, 1'b0, 1'b0);
            else applyStimulus(SYNC_DATA, 1'b1, 1'b1);
            if (c == 33) checkOutput("t5_gap_hold", dat_o, lastDat);
            if (c == 64) checkOutput("t5_lock_64cyc", 66'(block_lock), 66'(0));
        end
        checkOutput("t5_lock_65cyc", 66'(block_lock), 66'(1));
        checkOutput("t5_noslip", 66'(slipSeen), 66'(0));
        applyStimulus(SYNC_DATA, 1'b0, 1'b0);
        checkOutput("t5_gap_vld", 66'(vld_o), 66'(0));
        checkOutput("t5_gap_dat", dat_o, lastDat);
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        checkOutput("t5_resume_vld", 66'(vld_o), 66'(1));

        $display("[TB] T6 reset while locked");
        rst = 1'b1;
        #1;
        checkOutput("t6_async_lock", 66'(block_lock), 66'(0));
        applyStimulus(SYNC_DATA, 1'b0, 1'b0);
        checkOutput("t6_rst_dat", dat_o, 66'(0));
        checkOutput("t6_rst_vld", 66'(vld_o), 66'(0));
        lastDat = '0;
        rst = 1'b0;
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(SYNC_DATA, 1'b1, 1'b1);
            if (i == 63) checkOutput("t6_relock_63", 66'(block_lock), 66'(0));
        end
        checkOutput("t6_relock_64", 66'(block_lock), 66'(1));

        $display("[TB] T6 reset during slip and wait");
        rst = 1'b1;
        applyStimulus(SYNC_DATA, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        applyStimulus(2'b11, 1'b1, 1'b1);
        checkOutput("t6_slip_on", 66'(slip_o), 66'(1));
        rst = 1'b1;
        #1;
        checkOutput("t6_slip_drop", 66'(slip_o), 66'(0));
        applyStimulus(SYNC_DATA, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        applyStimulus(2'b00, 1'b1, 1'b1);
        for (int w = 1; w <= 5; w++) applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        rst = 1'b1;
        applyStimulus(SYNC_DATA, 1'b0, 1'b0);
        checkOutput("t6_wait_rst_lock", 66'(block_lock), 66'(0));
        checkOutput("t6_wait_rst_slip", 66'(slip_o), 66'(0));
        rst = 1'b0;
        applyStimulus(SYNC_DATA, 1'b1, 1'b1);
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(SYNC_CTRL, 1'b1, 1'b1);
            if (i == 63) checkOutput("t6_wrelock_63", 66'(block_lock), 66'(0));
        end
        checkOutput("t6_wrelock_64", 66'(block_lock), 66'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
